btn_pulse_gen: RTL and testbench

Converts a raw, bouncy, level-held push button into registered single-cycle event pulses: press, long-press, auto-repeat and release, plus a clean debounced level. It sits between the board push-button pins and the door-lock key/command logic. It performs the inverse of the LED stretcher: a long held level in, one-clock pulses out. All timing is in `clk` cycles, with 50 MHz defaults.

---
 rtl/btn_pulse_gen_if.sv | 21 ++
 rtl/btn_pulse_gen.sv | 126 ++++++++++++
 tb/tb_btn_pulse_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/btn_pulse_gen_if.sv
// Push-button event bus: raw button level in, debounced level and one-cycle event pulses out.
// "release" is a reserved word in SystemVerilog, so the release pulse is carried as rel.
`timescale 1ns/1ps
interface btn_pulse_gen_if;
    logic btn;
    logic btn_db;
    logic press;
    logic long_press;
    logic rep;
    logic rel;

    modport master (
        output btn,
        input  btn_db, press, long_press, rep, rel
    );

    modport slave (
        input  btn,
        output btn_db, press, long_press, rep, rel
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Debounces a raw push button and emits registered one-cycle press / long-press /
// auto-repeat / release pulses plus a clean debounced level.
//   state      | meaning
//   S_IDLE     | button released and debounced
//   S_DB_PRESS | rising level seen, debouncing the press
//   S_HELD     | press accepted, timing toward long press
//   S_LONG     | long press issued, auto-repeat running
//   S_DB_REL   | falling level seen, debouncing the release
`timescale 1ns/1ps
module btn_pulse_gen #(
    parameter logic [25:0] T_DB   = 26'h0F4_240,
    parameter logic [25:0] T_LONG = 26'h2FA_F080,
    parameter logic [25:0] T_REP  = 26'h098_9680
) (
    input  logic           clk,
    input  logic           rst,
    btn_pulse_gen_if.slave bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DB_PRESS = 3'd1;
    localparam logic [2:0] S_HELD     = 3'd2;
    localparam logic [2:0] S_LONG     = 3'd3;
    localparam logic [2:0] S_DB_REL   = 3'd4;

    logic [2:0]  state;
    logic        s1;
    logic        btn_s;
    logic [25:0] db_cnt;
    logic [25:0] hold_cnt;
    logic [25:0] rep_cnt;
    logic        long_f;
    logic        btn_db_q;
    logic        press_q;
    logic        long_press_q;
    logic        rep_q;
    logic        rel_q;

    assign bus.btn_db     = btn_db_q;
    assign bus.press      = press_q;
    assign bus.long_press = long_press_q;
    assign bus.rep        = rep_q;
    assign bus.rel        = rel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            s1           <= 1'b0;
            btn_s        <= 1'b0;
            db_cnt       <= '0;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            long_f       <= 1'b0;
            btn_db_q     <= 1'b0;
            press_q      <= 1'b0;
            long_press_q <= 1'b0;
            rep_q        <= 1'b0;
            rel_q        <= 1'b0;
        end else begin
            s1           <= bus.btn;
            btn_s        <= s1;
            press_q      <= 1'b0;
            long_press_q <= 1'b0;
            rep_q        <= 1'b0;
            rel_q        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (btn_s) begin
                        state  <= S_DB_PRESS;
                        db_cnt <= T_DB - 26'd1;
                    end
                end
                S_DB_PRESS: begin
                    if (!btn_s) begin
                        state <= S_IDLE;
                    end else if (db_cnt == '0) begin
                        state    <= S_HELD;
                        press_q  <= 1'b1;
                        btn_db_q <= 1'b1;
                        hold_cnt <= T_LONG - 26'd1;
                        long_f   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt - 26'd1;
                    end
                end
                S_HELD: begin
                    if (!btn_s) begin
                        state  <= S_DB_REL;
                        db_cnt <= T_DB - 26'd1;
                    end else if (hold_cnt == '0) begin
                        state        <= S_LONG;
                        long_press_q <= 1'b1;
                        rep_cnt      <= T_REP - 26'd1;
                        long_f       <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 26'd1;
                    end
                end
                S_LONG: begin
                    if (!btn_s) begin
                        state  <= S_DB_REL;
                        db_cnt <= T_DB - 26'd1;
                    end else if (rep_cnt == '0) begin
                        rep_q   <= 1'b1;
                        rep_cnt <= T_REP - 26'd1;
                    end else begin
                        rep_cnt <= rep_cnt - 26'd1;
                    end
                end
                S_DB_REL: begin
                    // hold_cnt/rep_cnt stay frozen so a release bounce resumes the old cadence
                    if (btn_s) begin
                        state <= long_f ? S_LONG : S_HELD;
                    end else if (db_cnt == '0) begin
                        state    <= S_IDLE;
                        rel_q    <= 1'b1;
                        btn_db_q <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt - 26'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen: T_DB=4, T_LONG=10, T_REP=3, plus a T_DB=1 instance.
// Output vectors are {btn_db, press, long_press, rep, rel}; edge e is the e-th edge of a scenario.
`timescale 1ns/1ps
module tb_btn_pulse_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    btn_pulse_gen_if bus0 ();
    btn_pulse_gen_if bus1 ();

    assign bus1.btn = bus0.btn;

    btn_pulse_gen #(.T_DB(26'd4), .T_LONG(26'd10), .T_REP(26'd3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    btn_pulse_gen #(.T_DB(26'd1), .T_LONG(26'd10), .T_REP(26'd3)) u_dut_db1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs0();
        return {bus0.btn_db, bus0.press, bus0.long_press, bus0.rep, bus0.rel};
    endfunction

    function automatic logic [4:0] outs1();
        return {bus1.btn_db, bus1.press, bus1.long_press, bus1.rep, bus1.rel};
    endfunction

    task automatic chk(input logic [4:0] got, input logic [4:0] exp, input string tag, input int e);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, e, got, exp);
        end
    endtask

    // Drive btn so the next edge samples b, then check just after that edge.
    task automatic cyc(input logic b, input logic [4:0] exp, input string tag, input int e);
        bus0.btn = b;
        @(posedge clk);
        #1;
        chk(outs0(), exp, tag, e);
    endtask

    initial begin
        bus0.btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(outs0(), 5'b00000, "reset", 0);
        chk(outs1(), 5'b00000, "reset_db1", 0);
        rst = 1'b0;

        // Clean short press, 10 cycles high
        for (int e = 0; e <= 21; e++) begin
            cyc(e < 10, {e >= 6 && e <= 15, e == 6, 1'b0, 1'b0, e == 16}, "short", e);
            chk(outs1(), {e >= 3 && e <= 12, e == 3, 1'b0, 1'b0, e == 13}, "short_db1", e);
        end

        // Press bounce 1,1,0,0,1,1,0,0 then stable high from edge 8 to 19
        for (int e = 0; e <= 30; e++) begin
            cyc((e < 2) || (e >= 4 && e < 6) || (e >= 8 && e <= 19),
                {e >= 14 && e <= 25, e == 14, 1'b0, 1'b0, e == 26}, "bounce", e);
        end

        // Long hold, 30 cycles high
        for (int e = 0; e <= 40; e++) begin
            cyc(e < 30,
                {e >= 6 && e <= 35, e == 6, e == 16,
                 e == 19 || e == 22 || e == 25 || e == 28 || e == 31, e == 36}, "long", e);
        end

        // Two-cycle release bounce in LONG; rep resumes from frozen count
        for (int e = 0; e <= 42; e++) begin
            cyc(!(e == 20 || e == 21) && e < 32,
                {e >= 6 && e <= 37, e == 6, e == 16,
                 e == 19 || e == 25 || e == 28 || e == 31, e == 38}, "relbounce", e);
        end

        // Four-cycle drop in HELD: db_cnt reaches 0 as btn_s returns, hold count frozen
        for (int e = 0; e <= 33; e++) begin
            cyc(!(e >= 8 && e <= 11) && e <= 22,
                {e >= 6 && e <= 28, e == 6, e == 21, e == 24, e == 29}, "heldfreeze", e);
        end

        // Async reset mid-LONG with the button still held
        for (int e = 0; e <= 17; e++) begin
            cyc(1'b1, {e >= 6, e == 6, e == 16, 1'b0, 1'b0}, "prereset", e);
        end
        #2;
        rst = 1'b1;
        #1;
        chk(outs0(), 5'b00000, "rst_async", 17);
        cyc(1'b1, 5'b00000, "in_reset", 18);
        cyc(1'b1, 5'b00000, "in_reset", 19);
        rst = 1'b0;
        for (int e = 20; e <= 40; e++) begin
            cyc(e <= 30, {e >= 26 && e <= 36, e == 26, 1'b0, 1'b0, e == 37}, "postreset", e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
